// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline control types for the hazard unit.
package pipe_pkg;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {RUN, MULWAIT, MULLAST} state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between EX load and ID sources.
module hazard_detect (
    input  logic [4:0] IDRs1_i,
    input  logic [4:0] IDRs2_i,
    input  logic       IDUsesRs2_i,
    input  logic       EXMemRead_i,
    input  logic [4:0] EXRd_i,
    output logic       LoadUse_o
);
    assign LoadUse_o = EXMemRead_i && (EXRd_i != 5'd0) &&
                       ((EXRd_i == IDRs1_i) || (IDUsesRs2_i && (EXRd_i == IDRs2_i)));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with multi-cycle multiply hold and perf counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IDRs1_i,
    input  logic [4:0]  IDRs2_i,
    input  logic        IDUsesRs2_i,
    input  logic        EXMemRead_i,
    input  logic [4:0]  EXRd_i,
    input  logic        EXMul_i,
    input  logic        BranchTaken_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXWrite_o,
    output logic        IDEXBubble_o,
    output logic        Busy_o,
    output logic [15:0] StallCnt_o,
    output logic [15:0] FlushCnt_o
);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lu_raw, mul_stall, load_use;

    hazard_detect u_detect (
        .IDRs1_i    (IDRs1_i),
        .IDRs2_i    (IDRs2_i),
        .IDUsesRs2_i(IDUsesRs2_i),
        .EXMemRead_i(EXMemRead_i),
        .EXRd_i     (EXRd_i),
        .LoadUse_o  (lu_raw)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= RUN;
            cnt        <= '0;
            StallCnt_o <= '0;
            FlushCnt_o <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (!PCWrite_o && StallCnt_o != 16'hFFFF) StallCnt_o <= StallCnt_o + 16'd1;
            if (IFIDFlush_o && FlushCnt_o != 16'hFFFF) FlushCnt_o <= FlushCnt_o + 16'd1;
        end
    end

    // MULLAST exists so a multiply still held in EX is not restarted on release.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RUN: if (EXMul_i) begin
                cnt_n   = CNT_W'(MUL_LAT - 2);
                state_n = (MUL_LAT == 2) ? MULLAST : MULWAIT;
            end
            MULWAIT: begin
                cnt_n   = cnt - 1'b1;
                state_n = (cnt == CNT_W'(1)) ? MULLAST : MULWAIT;
            end
            default: state_n = RUN;
        endcase
        mul_stall    = !rst_i && (state == MULWAIT || (state == RUN && EXMul_i));
        load_use     = !rst_i && !mul_stall && lu_raw;
        PCWrite_o    = !(mul_stall || load_use);
        IFIDWrite_o  = !(mul_stall || load_use);
        IDEXWrite_o  = !mul_stall;
        IDEXBubble_o = load_use;
        IFIDFlush_o  = !rst_i && BranchTaken_i && !mul_stall && !load_use;
        Busy_o       = mul_stall;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table, directed and random checks of hazard_ctrl at MUL_LAT 4 and 2.
module tb_hazard_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i, IDUsesRs2_i, EXMemRead_i, EXMul_i, BranchTaken_i;
    logic [4:0]  IDRs1_i, IDRs2_i, EXRd_i;
    logic [1:0]  pcw, ifw, fl, idw, bub, busy;
    logic [15:0] sc [2];
    logic [15:0] fc [2];

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MUL_LAT(4)) u4 (
        .clk_i(clk_i), .rst_i(rst_i), .IDRs1_i(IDRs1_i), .IDRs2_i(IDRs2_i),
        .IDUsesRs2_i(IDUsesRs2_i), .EXMemRead_i(EXMemRead_i), .EXRd_i(EXRd_i),
        .EXMul_i(EXMul_i), .BranchTaken_i(BranchTaken_i),
        .PCWrite_o(pcw[0]), .IFIDWrite_o(ifw[0]), .IFIDFlush_o(fl[0]),
        .IDEXWrite_o(idw[0]), .IDEXBubble_o(bub[0]), .Busy_o(busy[0]),
        .StallCnt_o(sc[0]), .FlushCnt_o(fc[0])
    );

    hazard_ctrl #(.MUL_LAT(2)) u2 (
        .clk_i(clk_i), .rst_i(rst_i), .IDRs1_i(IDRs1_i), .IDRs2_i(IDRs2_i),
        .IDUsesRs2_i(IDUsesRs2_i), .EXMemRead_i(EXMemRead_i), .EXRd_i(EXRd_i),
        .EXMul_i(EXMul_i), .BranchTaken_i(BranchTaken_i),
        .PCWrite_o(pcw[1]), .IFIDWrite_o(ifw[1]), .IFIDFlush_o(fl[1]),
        .IDEXWrite_o(idw[1]), .IDEXBubble_o(bub[1]), .Busy_o(busy[1]),
        .StallCnt_o(sc[1]), .FlushCnt_o(fc[1])
    );

    int passed = 0, total = 0;

    // reference model: remaining stall cycles of the current multiply, plus a
    // one-cycle window after release in which a still-present EXMul is ignored
    int lat  [2] = '{4, 2};
    int rem  [2];
    int scnt [2];
    int fcnt [2];
    bit last [2];

    logic [5:0]  g   [2];
    logic [15:0] gsc [2];
    logic [15:0] gfc [2];

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       us2, mr;
        logic [4:0] rd;
        logic       bt;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, got, exp);
    endtask

    function automatic logic [5:0] dut_outs(input int k);
        return {pcw[k], ifw[k], fl[k], idw[k], bub[k], busy[k]};
    endfunction

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, Busy}
    function automatic logic [5:0] exp_outs(input int k);
        bit stall, lu;
        if (rst_i) return 6'b110100;
        stall = rem[k] > 0 || (!last[k] && EXMul_i);
        lu = !stall && EXMemRead_i && EXRd_i != 0 &&
             (EXRd_i == IDRs1_i || (IDUsesRs2_i && EXRd_i == IDRs2_i));
        return {!(stall || lu), !(stall || lu), !stall && !lu && BranchTaken_i, !stall, lu, stall};
    endfunction

    task automatic model_update(input int k);
        logic [5:0] e;
        e = exp_outs(k);
        if (rst_i) begin
            rem[k] = 0; last[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end else begin
            if (!e[5] && scnt[k] < 65535) scnt[k]++;
            if (e[3] && fcnt[k] < 65535) fcnt[k]++;
            if (rem[k] > 0) begin
                rem[k]--;
                last[k] = rem[k] == 0;
            end else if (last[k]) last[k] = 0;
            else if (EXMul_i) begin
                rem[k]  = lat[k] - 2;
                last[k] = lat[k] == 2;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [4:0] a, input logic [4:0] b, input logic u,
                         input logic m, input logic [4:0] d, input logic x, input logic t);
        rst_i = r; IDRs1_i = a; IDRs2_i = b; IDUsesRs2_i = u;
        EXMemRead_i = m; EXRd_i = d; EXMul_i = x; BranchTaken_i = t;
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            g[k] = dut_outs(k); gsc[k] = sc[k]; gfc[k] = fc[k];
            chk($sformatf("model_outs%0d", lat[k]), g[k], exp_outs(k));
            chk($sformatf("model_stallcnt%0d", lat[k]), gsc[k], scnt[k]);
            chk($sformatf("model_flushcnt%0d", lat[k]), gfc[k], fcnt[k]);
            model_update(k);
        end
        @(posedge clk_i);
        #1;
    endtask

    logic [3:0]  bz4, bz2;
    logic [15:0] base;

    initial begin
        tbl[0] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd2,  1'b0, 6'b000110};
        tbl[1] = '{5'd1,  5'd2,  1'b0, 1'b1, 5'd2,  1'b0, 6'b110100};
        tbl[2] = '{5'd3,  5'd3,  1'b1, 1'b0, 5'd3,  1'b0, 6'b110100};
        tbl[3] = '{5'd3,  5'd3,  1'b1, 1'b0, 5'd3,  1'b1, 6'b111100};
        tbl[4] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 6'b111100};
        tbl[5] = '{5'd9,  5'd4,  1'b1, 1'b1, 5'd9,  1'b1, 6'b000110};
        tbl[6] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 6'b000110};
        tbl[7] = '{5'd8,  5'd9,  1'b1, 1'b1, 5'd10, 1'b0, 6'b110100};
        rst_i = 1; IDRs1_i = 0; IDRs2_i = 0; IDUsesRs2_i = 0;
        EXMemRead_i = 0; EXRd_i = 0; EXMul_i = 0; BranchTaken_i = 0;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; last[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
        repeat (2) @(posedge clk_i);
        #1;
        cycle(1, 5, 5, 1, 1, 5, 1, 1);
        chk("rst_outs", g[0], 6'b110100);
        chk("rst_outs_lat2", g[1], 6'b110100);
        chk("rst_stallcnt", gsc[0], 0);
        cycle(0, 5, 0, 0, 1, 5, 0, 0);
        chk("load_use", g[0], 6'b000110);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        chk("load_rd0", g[0], 6'b110100);
        chk("load_stallcnt", gsc[0], 1);
        cycle(0, 1, 7, 0, 1, 7, 0, 0);
        chk("rs2_unused", g[0], 6'b110100);
        for (int i = 0; i < 8; i++) begin
            cycle(0, tbl[i].rs1, tbl[i].rs2, tbl[i].us2, tbl[i].mr, tbl[i].rd, 0, tbl[i].bt);
            chk($sformatf("tbl%0d", i), g[0], tbl[i].exp);
            chk($sformatf("tbl%0d_lat2", i), g[1], tbl[i].exp);
        end
        base = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 1, 0);
            bz4[i] = g[0][0];
            bz2[i] = g[1][0];
            if (i == 0) base = gsc[0];
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mul4_busy", bz4, 4'b0111);
        chk("mul2_busy", bz2[1:0], 2'b01);
        chk("mul4_stallcnt", gsc[0] - base, 3);
        cycle(0, 5, 0, 0, 1, 5, 0, 1);
        chk("branch_vs_load", g[0], 6'b000110);
        base = gfc[0];
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk("branch_flush", g[0], 6'b111100);
        chk("branch_suppressed_cnt", gfc[0], base);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("branch_flushcnt", gfc[0], base + 16'd1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk("branch_in_mulwait_flush", g[0][3], 0);
        chk("branch_in_mulwait_busy", g[0][0], 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_mid_mul_busy", g[0][0], 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("after_rst_outs", g[0], 6'b110100);
        chk("after_rst_stallcnt", gsc[0], 0);
        chk("after_rst_flushcnt", gfc[0], 0);
        IDRs1_i = 5; EXMemRead_i = 1; EXRd_i = 5;
        repeat (65540) @(posedge clk_i);
        #1;
        scnt[0] = 65535; scnt[1] = 65535;
        cycle(0, 5, 0, 0, 1, 5, 0, 0);
        chk("stall_saturated", gsc[0], 16'hFFFF);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_sat_hold", gsc[0], 16'hFFFF);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (400)
            cycle($urandom_range(0, 49) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, legal range 2..16: total EX-stage occupancy, in cycles, of a multiply.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  clock, the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- IDRs1_i  in  5  rs1 of the instruction in ID.
- IDRs2_i  in  5  rs2 of the instruction in ID.
- IDUsesRs2_i  in  1  ID instruction reads rs2.
- EXMemRead_i  in  1  instruction in EX is a load.
- EXRd_i  in  5  rd of the instruction in EX.
- EXMul_i  in  1  instruction in EX is a multiply.
- BranchTaken_i  in  1  branch resolved taken in ID this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register load enable.
- IFIDFlush_o  out  1  IF/ID register clear to NOP.
- IDEXWrite_o  out  1  ID/EX register load enable.
- IDEXBubble_o  out  1  force ID/EX control fields (RegWrite, MemtoReg, MemRead, MemWrite) to 0.
- Busy_o  out  1  multiply stall in progress.
- StallCnt_o  out  16  stall-cycle performance counter.
- FlushCnt_o  out  16  flush performance counter.

Function
REQ-003 SHALL implement FSM states RUN, MULWAIT and MULLAST, plus a 4-bit down-counter cnt.
REQ-004 A mul stall occurs when state=MULWAIT, or when state=RUN and EXMul_i=1.
- Outputs during a mul stall: PCWrite_o=0, IFIDWrite_o=0, IDEXWrite_o=0, IFIDFlush_o=0, IDEXBubble_o=0, Busy_o=1.
REQ-005 RUN with EXMul_i=1 SHALL load cnt<=MUL_LAT-2.
- Next state is MULLAST if MUL_LAT=2, else MULWAIT.
REQ-006 MULWAIT SHALL decrement cnt each cycle, and go to MULLAST in the cycle cnt=1.
REQ-007 MULLAST SHALL ignore EXMul_i, apply the RUN output rules for load-use and branch, and always return to RUN.
REQ-008 Net effect: a multiply holds the pipeline for exactly MUL_LAT-1 cycles.
REQ-009 Load-use hazard: state≠MULWAIT, no mul stall, EXMemRead_i=1, EXRd_i≠0, and (EXRd_i=IDRs1_i, or IDUsesRs2_i=1 and EXRd_i=IDRs2_i).
- Response: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, IDEXWrite_o=1, IFIDFlush_o=0.
REQ-010 Branch flush: BranchTaken_i=1 with no mul stall and no load-use hazard.
- Response: IFIDFlush_o=1, PCWrite_o=1, IFIDWrite_o=1, IDEXWrite_o=1, IDEXBubble_o=0.
REQ-011 Priority SHALL be mul stall > load-use > branch flush; a suppressed branch is re-presented by ID in a later cycle.
REQ-012 With no condition active, outputs SHALL be PCWrite_o=1, IFIDWrite_o=1, IDEXWrite_o=1, IFIDFlush_o=0, IDEXBubble_o=0, Busy_o=0.
REQ-013 StallCnt_o SHALL increment by 1 per cycle with PCWrite_o=0, saturating at 16'hFFFF.
REQ-014 FlushCnt_o SHALL increment by 1 per cycle with IFIDFlush_o=1, saturating at 16'hFFFF.
REQ-015 All outputs except the counters SHALL be combinational from state, cnt and inputs; there SHALL be no latched hazard outputs.

Reset
REQ-016 rst_i=1 at a clock edge SHALL set state=RUN, cnt=0, StallCnt_o=0 and FlushCnt_o=0, including mid-multiply.
REQ-017 While rst_i=1, the control outputs SHALL present the REQ-012 defaults, with Busy_o=0 and no counter increment.

Structure
REQ-018 State encoding (RUN/MULWAIT/MULLAST) and the counter width constant SHALL live in shared package pipe_pkg.
REQ-019 Load-use compare logic SHALL be sub-module hazard_detect (combinational); the FSM and counters SHALL stay in hazard_ctrl.

Verification
REQ-020 Directed scenarios:
- Load x5 in EX with IDRs1_i=5 -> 1 cycle: PCWrite_o=0, IDEXBubble_o=1; StallCnt_o=1.
- Same load, EXRd_i=0, IDRs1_i=0 -> no stall.
- IDUsesRs2_i=0 with IDRs2_i=EXRd_i=7 -> no stall.
- MUL_LAT=4, EXMul_i held 4 cycles -> Busy_o=1 for 3 cycles, released in cycle 4; StallCnt_o=3.
- MUL_LAT=2 -> Busy_o=1 for exactly 1 cycle.
- BranchTaken_i=1 together with a load-use hazard -> bubble only, FlushCnt_o unchanged.
- Next cycle, BranchTaken_i=1 alone -> IFIDFlush_o=1, FlushCnt_o=1.
- BranchTaken_i=1 during MULWAIT -> IFIDFlush_o=0.
- rst_i=1 in MULWAIT (cnt=1) -> next cycle state RUN, Busy_o=0, counters 0.
- Counter preloaded near saturation via 65540 forced stall cycles -> StallCnt_o holds 16'hFFFF.
